// File: rtl/fork3_sync.sv
`default_nettype none
// ============================================================================
// Module   : fork3_sync
// Desc     : 4-phase handshake fork from one upstream to three downstream
//            branches, with every handshake input brought in through its own
//            synchroniser. Define FORK3_TIMEOUT_EN for the sticky watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module fork3_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_W   = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_in_i,
    output logic ack_in_o,
    output logic req_out1_o,
    output logic req_out2_o,
    output logic req_out3_o,
    input  logic ack_out1_i,
    input  logic ack_out2_i,
    input  logic ack_out3_i,
    output logic busy_o
`ifdef FORK3_TIMEOUT_EN
    ,
    output logic timeout_o
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FORK  = 2'd1,
        ST_ACKED = 2'd2,
        ST_RTZ   = 2'd3
    } state_t;

    // bit 0 = req_in, bits 3:1 = ack_out3..ack_out1
    logic [3:0] w_async_in;
    logic [3:0] w_sync;
    logic       w_req_s;
    logic [2:0] w_ack_s;

    assign w_async_in = {ack_out3_i, ack_out2_i, ack_out1_i, req_in_i};

    for (genvar gi = 0; gi < 4; gi++) begin : g_sync
        logic [SYNC_STAGES-1:0] r_chain;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_chain <= '0;
            end else begin
                r_chain[0] <= w_async_in[gi];
                for (int j = 1; j < SYNC_STAGES; j++) begin
                    r_chain[j] <= r_chain[j-1];
                end
            end
        end

        assign w_sync[gi] = r_chain[SYNC_STAGES-1];
    end

    assign w_req_s = w_sync[0];
    assign w_ack_s = w_sync[3:1];

    state_t     r_state;
    state_t     w_state_next;
    logic [2:0] r_ack_seen;
    logic [2:0] w_ack_seen_next;
    logic       r_req_out;
    logic       r_ack_in;
    logic       r_busy;
    logic       w_req_out_next;
    logic       w_ack_in_next;
    logic       w_busy_next;

    always_comb begin
        w_state_next    = r_state;
        w_ack_seen_next = r_ack_seen;
        case (r_state)
            ST_IDLE: begin
                w_ack_seen_next = 3'b000;
                if (w_req_s) begin
                    w_state_next = ST_FORK;
                end
            end
            ST_FORK: begin
                // Flags are sticky so an early or withdrawn ack still counts,
                // and completion needs every branch to have answered.
                w_ack_seen_next = r_ack_seen | w_ack_s;
                if (&w_ack_seen_next) begin
                    w_state_next = ST_ACKED;
                end
            end
            ST_ACKED: begin
                if (!w_req_s) begin
                    w_state_next = ST_RTZ;
                end
            end
            ST_RTZ: begin
                if (w_ack_s == 3'b000) begin
                    w_state_next    = ST_IDLE;
                    w_ack_seen_next = 3'b000;
                end
            end
            default: begin
                w_state_next    = ST_IDLE;
                w_ack_seen_next = 3'b000;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same
    // edge as the state itself, yet come straight from flops.
    always_comb begin
        w_req_out_next = (w_state_next == ST_FORK) || (w_state_next == ST_ACKED);
        w_ack_in_next  = (w_state_next == ST_ACKED) || (w_state_next == ST_RTZ);
        w_busy_next    = (w_state_next != ST_IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_ack_seen <= 3'b000;
            r_req_out  <= 1'b0;
            r_ack_in   <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_ack_seen <= w_ack_seen_next;
            r_req_out  <= w_req_out_next;
            r_ack_in   <= w_ack_in_next;
            r_busy     <= w_busy_next;
        end
    end

    assign req_out1_o = r_req_out;
    assign req_out2_o = r_req_out;
    assign req_out3_o = r_req_out;
    assign ack_in_o   = r_ack_in;
    assign busy_o     = r_busy;

`ifdef FORK3_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] C_WDOG_MAX = '1;

    logic [TIMEOUT_W-1:0] r_wdog_cnt;
    logic [TIMEOUT_W-1:0] w_wdog_cnt_next;
    logic                 r_timeout;

    always_comb begin
        w_wdog_cnt_next = r_wdog_cnt;
        if (w_state_next != r_state) begin
            w_wdog_cnt_next = '0;
        end else if (((r_state == ST_FORK) || (r_state == ST_RTZ)) &&
                     (r_wdog_cnt != C_WDOG_MAX)) begin
            w_wdog_cnt_next = r_wdog_cnt + 1'b1;
        end
    end

    // Flag only reports the stall; the handshake keeps waiting regardless.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wdog_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_wdog_cnt <= w_wdog_cnt_next;
            if (w_wdog_cnt_next == C_WDOG_MAX) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign timeout_o = r_timeout;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fork3_sync.sv
`default_nettype none
// Testbench for fork3_sync: table of handshake scenarios with an event
// scoreboard, plus hand-written reset and watchdog sequences.
module tb_fork3_sync;

    localparam int S = 2;
`ifdef FORK3_TIMEOUT_EN
    localparam int TW = 4;
`else
    localparam int TW = 8;
`endif

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic req_in_i = 1'b0;
    logic ack_in_o;
    logic req_out1_o, req_out2_o, req_out3_o;
    logic ack_out1_i = 1'b0;
    logic ack_out2_i = 1'b0;
    logic ack_out3_i = 1'b0;
    logic busy_o;
`ifdef FORK3_TIMEOUT_EN
    logic timeout_o;
`endif

    fork3_sync #(
        .SYNC_STAGES (S),
        .TIMEOUT_W   (TW)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_in_i   (req_in_i),
        .ack_in_o   (ack_in_o),
        .req_out1_o (req_out1_o),
        .req_out2_o (req_out2_o),
        .req_out3_o (req_out3_o),
        .ack_out1_i (ack_out1_i),
        .ack_out2_i (ack_out2_i),
        .ack_out3_i (ack_out3_i),
        .busy_o     (busy_o)
`ifdef FORK3_TIMEOUT_EN
        ,
        .timeout_o  (timeout_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    // Output vector layout: {req_out1, req_out2, req_out3, ack_in, busy}
    typedef struct {
        int         edge_no;
        logic [4:0] vec;
    } ev_t;

    typedef struct {
        int d1, d2, d3;     // ack raise delay after req_outs rise (cycles)
        bit glitch2;        // ack2 is a one-cycle pulse only
        bit early;          // req_in drops one cycle into FORK
        int q;              // req_in drop delay after ack_in rises
        int z;              // ack drop delay after entering RTZ
        int exp_fork;       // req_in drive -> req_outs high
        int exp_ack;        // req_outs high -> ack_in high
        int exp_rtz;        // ack_in high -> req_outs low
        int exp_idle;       // ack drop drive -> idle
    } scn_t;

    ev_t        exp_q[$];
    scn_t       tbl[7];
    int         n_vec = 0;
    int         n_err = 0;
    bit         mon_en = 1'b0;
    logic [4:0] prev_vec = 5'b0;

    function automatic logic [4:0] out_vec();
        return {req_out1_o, req_out2_o, req_out3_o, ack_in_o, busy_o};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push_ev(input int edge_no, input logic [4:0] vec);
        ev_t ev;
        ev.edge_no = edge_no;
        ev.vec     = vec;
        exp_q.push_back(ev);
    endtask

    // Advance to the next falling edge and score any output change.
    task automatic tick();
        logic [4:0] v;
        ev_t        e;
        @(negedge clk_i);
        if (mon_en) begin
            v = out_vec();
            if (v !== prev_vec) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_change: got %b at edge %0d, required %b", v, cyc, prev_vec);
                end else begin
                    e = exp_q.pop_front();
                    if (e.edge_no != cyc || e.vec !== v) begin
                        n_err++;
                        $display("FAIL event: got edge %0d out %b, required edge %0d out %b",
                                 cyc, v, e.edge_no, e.vec);
                    end
                end
            end
            prev_vec = v;
        end
    endtask

    task automatic run_scn(input scn_t s);
        int e0, r, a_e, drop_n, rtz_e, ackdrop_n, idle_e;
        tick();
        e0        = cyc;
        r         = e0 + s.exp_fork;
        a_e       = r + s.exp_ack;
        drop_n    = s.early ? r + 1 : a_e + s.q;
        rtz_e     = a_e + s.exp_rtz;
        ackdrop_n = rtz_e + s.z;
        idle_e    = ackdrop_n + s.exp_idle;
        push_ev(r,      5'b11101);
        push_ev(a_e,    5'b11111);
        push_ev(rtz_e,  5'b00011);
        push_ev(idle_e, 5'b00000);
        for (int t = e0; t <= idle_e + 2; t++) begin
            if (t != e0) tick();
            req_in_i   = (t < drop_n);
            ack_out1_i = (t >= r + s.d1) && (t < ackdrop_n);
            ack_out2_i = s.glitch2 ? (t == r + s.d2)
                                   : ((t >= r + s.d2) && (t < ackdrop_n));
            ack_out3_i = (t >= r + s.d3) && (t < ackdrop_n);
        end
    endtask

    task automatic clear_inputs();
        req_in_i   = 1'b0;
        ack_out1_i = 1'b0;
        ack_out2_i = 1'b0;
        ack_out3_i = 1'b0;
    endtask

    initial begin
        //            d1 d2 d3 g     early q  z  fork ack rtz idle
        tbl[0] = '{3, 3, 3, 1'b0, 1'b0, 2, 2, 3,   6,  5,  3};  // simultaneous acks
        tbl[1] = '{1, 5, 9, 1'b0, 1'b0, 0, 1, 3,  12,  3,  3};  // staggered acks
        tbl[2] = '{4, 0, 6, 1'b1, 1'b0, 1, 0, 3,   9,  4,  3};  // ack2 glitch first
        tbl[3] = '{0, 0, 0, 1'b0, 1'b0, 0, 0, 3,   3,  3,  3};  // immediate acks
        tbl[4] = '{2, 7, 4, 1'b0, 1'b1, 0, 1, 3,  10,  1,  3};  // req drops in FORK
        tbl[5] = '{9, 2, 0, 1'b0, 1'b0, 3, 2, 3,  12,  6,  3};  // reverse stagger
        tbl[6] = '{5, 3, 1, 1'b1, 1'b0, 0, 0, 3,   8,  3,  3};  // ack2 glitch mid

        #1;
        check("reset_req_outs", {29'd0, req_out1_o, req_out2_o, req_out3_o}, 32'd0);
        check("reset_ack_in",   {31'd0, ack_in_o}, 32'd0);
        check("reset_busy",     {31'd0, busy_o},   32'd0);
`ifdef FORK3_TIMEOUT_EN
        check("reset_timeout",  {31'd0, timeout_o}, 32'd0);
`endif
        repeat (3) @(negedge clk_i);
        rst_i    = 1'b0;
        prev_vec = 5'b0;
        mon_en   = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_scn(tbl[i]);
        end

        // Reset in the middle of ACKED
        mon_en = 1'b0;
        @(negedge clk_i);
        req_in_i   = 1'b1;
        ack_out1_i = 1'b1;
        ack_out2_i = 1'b1;
        ack_out3_i = 1'b1;
        for (int k = 0; k < 20 && !ack_in_o; k++) @(negedge clk_i);
        check("acked_reached", {31'd0, ack_in_o}, 32'd1);
        #2 rst_i = 1'b1;
        #1;
        check("async_rst_ack_in",   {31'd0, ack_in_o}, 32'd0);
        check("async_rst_req_outs", {29'd0, req_out1_o, req_out2_o, req_out3_o}, 32'd0);
        check("async_rst_busy",     {31'd0, busy_o},   32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        clear_inputs();
        repeat (3) @(negedge clk_i);
        prev_vec = out_vec();
        mon_en   = 1'b1;
        run_scn(tbl[0]);
        run_scn(tbl[1]);

`ifdef FORK3_TIMEOUT_EN
        // ack3 never returns: watchdog fires on the 15th cycle in FORK
        mon_en = 1'b0;
        begin
            int r_e;
            @(negedge clk_i);
            req_in_i   = 1'b1;
            ack_out1_i = 1'b1;
            ack_out2_i = 1'b1;
            r_e = -1;
            for (int k = 0; k < 10 && r_e < 0; k++) begin
                @(negedge clk_i);
                if (req_out1_o) r_e = cyc;
            end
            check("wdog_fork_entered", {31'd0, (r_e >= 0)}, 32'd1);
            if (r_e >= 0) begin
                while (cyc < r_e + 14) @(negedge clk_i);
                check("wdog_before_max", {31'd0, timeout_o}, 32'd0);
                @(negedge clk_i);
                check("wdog_at_max",     {31'd0, timeout_o}, 32'd1);
                check("wdog_ack_in_low", {31'd0, ack_in_o},  32'd0);
                repeat (10) @(negedge clk_i);
                check("wdog_sticky",     {31'd0, timeout_o}, 32'd1);
                check("wdog_still_fork", {31'd0, ack_in_o, busy_o}, 32'd1);
            end
            #2 rst_i = 1'b1;
            #1;
            check("wdog_rst_clear", {31'd0, timeout_o}, 32'd0);
            @(negedge clk_i);
            rst_i = 1'b0;
            clear_inputs();
        end
`endif

        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL pending_events: got %0d unobserved, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fork3_sync.md
FORK3_SYNC -- requirements
Module: fork3_sync

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchroniser flops on every handshake input (legal 1..4).
REQ-002 SHALL have parameter TIMEOUT_W, default 8, watchdog counter width (legal 4..16; used only with FORK3_TIMEOUT_EN).
REQ-003 clk_i  input  1  single clock, all state on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 req_in_i  input  1  upstream 4-phase request.
REQ-006 ack_in_o  output  1  upstream 4-phase acknowledge.
REQ-007 req_out1_o, req_out2_o, req_out3_o  output  1 each  downstream requests, one per branch.
REQ-008 ack_out1_i, ack_out2_i, ack_out3_i  input  1 each  downstream acknowledges.
REQ-009 busy_o  output  1  high whenever FSM is not IDLE.
REQ-010 timeout_o  output  1  sticky watchdog flag (present only with FORK3_TIMEOUT_EN).

Function
REQ-011 SHALL pass req_in_i and each ack_outN_i through its own SYNC_STAGES-deep flop chain; FSM uses only synchronised values.
REQ-012 SHALL implement FSM states IDLE, FORK, ACKED, RTZ; all outputs registered, no combinational input-to-output path.
REQ-013 IDLE: req_outN_o=0, ack_in_o=0; synced req_in high -> FORK, asserting all three req_outN_o on the same edge.
REQ-014 Latency: req_in_i high at edge k -> req_outN_o high after edge k+SYNC_STAGES.
REQ-015 FORK: per-branch flag ack_seen[N] set on any cycle synced ack_outN is high; flags never clear inside FORK.
REQ-016 FORK -> ACKED on the edge where all three flags are (or become) set, including all three acks arriving in the same cycle; ack_in_o rises on that edge.
REQ-017 ACKED: req_outN_o stay high, ack_in_o=1; synced req_in low -> RTZ, dropping all req_outN_o on that edge.
REQ-018 RTZ: ack_in_o stays 1; when all three synced acks are low -> IDLE, ack_in_o falls on that edge, ack_seen cleared.
REQ-019 A branch acking early or withdrawing ack before others arrive SHALL NOT cause premature ack_in_o; completion requires all three flags.
REQ-020 req_in_i dropping while in FORK (protocol violation) SHALL be ignored; FSM waits in FORK for all acks.
REQ-021 busy_o=1 in FORK, ACKED, RTZ; 0 in IDLE.

Reset
REQ-022 rst_i high SHALL asynchronously force FSM=IDLE, all synchroniser flops=0, ack_seen=0, ack_in_o=0, req_outN_o=0, busy_o=0, counter=0, timeout_o=0.
REQ-023 Reset mid-handshake SHALL abort it immediately; after release the block behaves as from power-up.
REQ-024 First state change after release SHALL need synced req_in high, i.e. no earlier than SYNC_STAGES edges after release.

Configuration
REQ-025 Macro FORK3_TIMEOUT_EN defined: a TIMEOUT_W-bit counter increments each cycle in FORK or RTZ, clears on any state change, saturates at all-ones.
REQ-026 With FORK3_TIMEOUT_EN, timeout_o SHALL rise on the edge the counter reaches 2^TIMEOUT_W-1 and stay high until reset; FSM keeps waiting (no recovery).
REQ-027 Without FORK3_TIMEOUT_EN: no counter, no timeout_o port; handshake behaviour identical.

Verification
REQ-028 Full cycle, SYNC_STAGES=2: req_in_i up at edge 10, acks up 3 cycles after req_outs -> req_outN_o high after edge 12, ack_in_o high 2 edges after last ack synced; req_in down -> req_outs down, acks down -> ack_in_o low, busy_o low.
REQ-029 Staggered acks: ack1 at cycle +1, ack2 at +5, ack3 at +9 -> ack_in_o stays 0 until ack3 synced, rises exactly SYNC_STAGES edges after ack3.
REQ-030 Glitching branch: ack2 pulses high 1 cycle then low, ack1/ack3 arrive later -> ack_in_o still rises once ack1 and ack3 synced; RTZ completes.
REQ-031 Simultaneous acks: all three rise same cycle -> single FORK->ACKED transition, ack_in_o high after edge +SYNC_STAGES.
REQ-032 Reset mid-ACKED: rst_i pulsed for 1 cycle -> ack_in_o, req_outN_o, busy_o low immediately (before next clock edge); next req_in_i pulse starts clean handshake.
REQ-033 FORK3_TIMEOUT_EN, TIMEOUT_W=4: ack3 never returns -> timeout_o high on the 15th cycle in FORK, remains high; ack_in_o stays 0.
